sha256_msg_schedule: RTL and testbench

SHA-256 message-schedule generator. Accepts one 512-bit message block as 16 serial 32-bit words and emits the 64 schedule words W0..W63, one per accepted output handshake. It sits directly upstream of the compression-round datapath and its working-variable registers, supplying the W_t operand each round.

---
 rtl/sha256_pkg.sv | 38 +++
 rtl/sha256_msg_schedule_if.sv | 28 ++
 rtl/sha256_sched_next.sv | 33 +++
 rtl/sha256_msg_schedule.sv | 109 ++++++++++
 tb/tb_sha256_msg_schedule.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word geometry, schedule FSM states and the
// small/large sigma functions used by the schedule and compression stages.
`timescale 1ns/1ps
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int CNT_W       = 5;
  localparam int IDX_W       = 6;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-input / schedule-output handshake bundle for the message-schedule
// generator; slave is the generator's view, master the driver's view.
`timescale 1ns/1ps
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic       abort;
  logic       in_valid;
  logic       in_ready;
  word_t      in_word;
  logic       out_valid;
  logic       out_ready;
  word_t      out_w;
  logic [5:0] out_idx;
  logic       out_last;
  logic       busy;

  modport slave (
    input  abort, in_valid, in_word, out_ready,
    output in_ready, out_valid, out_w, out_idx, out_last, busy
  );

  modport master (
    output abort, in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_w, out_idx, out_last, busy
  );

endinterface

// File: rtl/sha256_sched_next.sv
// Next schedule word: sig1(w14) + w9 + sig0(w1) + w0 mod 2^32, reduced with
// two carry-save stages so only one carry-propagate adder sits on the path.
`timescale 1ns/1ps
module sha256_sched_next
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t next_w
);

  word_t s0;
  word_t s1;
  word_t sum_a;
  word_t carry_a;
  word_t sum_b;
  word_t carry_b;

  assign s0 = sig0(w1);
  assign s1 = sig1(w14);

  // Carries shift left by one; the bit shifted out is the discarded 2^32 term.
  assign sum_a   = s1 ^ w9 ^ s0;
  assign carry_a = ((s1 & w9) | (s1 & s0) | (w9 & s0)) << 1;

  assign sum_b   = sum_a ^ carry_a ^ w0;
  assign carry_b = ((sum_a & carry_a) | (sum_a & w0) | (carry_a & w0)) << 1;

  assign next_w = sum_b + carry_b;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: loads a 16-word block serially, then
// streams W0..W(ROUNDS-1) through a sliding 16-word window.
`timescale 1ns/1ps
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input logic                  CLK,
  input logic                  RST,
  sha256_msg_schedule_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             last_q;
  logic             last_d;
  word_t            win_q [BLOCK_WORDS];
  word_t            win_d [BLOCK_WORDS];
  word_t            next_w;
  logic             in_hs;
  logic             out_hs;

  sha256_sched_next u_next (
    .w0     (win_q[0]),
    .w1     (win_q[1]),
    .w9     (win_q[9]),
    .w14    (win_q[14]),
    .next_w (next_w)
  );

  assign in_hs  = (state_q == LOAD) && bus.in_valid;
  assign out_hs = (state_q == EMIT) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      win_d[i] = win_q[i];
    end

    if (bus.abort) begin
      state_d = LOAD;
      cnt_d   = '0;
      idx_d   = '0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        win_d[i] = '0;
      end
    end else if (in_hs) begin
      win_d[cnt_q[3:0]] = bus.in_word;
      if (cnt_q == LAST_CNT) begin
        state_d = EMIT;
        cnt_d   = '0;
        idx_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (out_hs) begin
      for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[BLOCK_WORDS-1] = next_w;
      // idx stays on the final index when the block completes.
      if (idx_q == LAST_IDX) begin
        state_d = LOAD;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    last_d = (state_d == EMIT) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_w     = win_q[0];
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q == EMIT) || (cnt_q != '0);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for the message-schedule generator: known "abc" and all-ones
// schedules, stalls, input gaps, back-to-back blocks, abort, async reset, ROUNDS=16.
`timescale 1ns/1ps
module tb_sha256_msg_schedule;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sha256_msg_schedule_if bus ();
  sha256_msg_schedule_if bus16 ();

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus16)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_hs  = 0;
  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  task automatic build_gold();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = msg[t];
      else exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_gold();
  endtask

  task automatic set_ones();
    for (int i = 0; i < 16; i++) msg[i] = 32'hFFFFFFFF;
    build_gold();
  endtask

  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check("in_ready_timeout", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    bus.in_word  = 32'h0;
  endtask

  task automatic send_block(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      send_word(msg[i]);
    end
  endtask

  // Drains the schedule into got_w; abort_at / stop_at (>=0) end the run early.
  task automatic collect(input bit stall, input bit junk_in, input int abort_at, input int stop_at);
    int          guard;
    logic        held;
    logic [31:0] hw;
    logic [5:0]  hi;
    guard = 0;
    held  = 1'b0;
    hw    = 32'h0;
    hi    = 6'h0;
    n_hs  = 0;
    check("valid_after_load", 32'(bus.out_valid), 1);
    while (n_hs < 64 && guard < 1000) begin
      if (held && bus.out_valid) begin
        check("stall_w", bus.out_w, hw);
        check("stall_idx", 32'(bus.out_idx), 32'(hi));
      end
      if (junk_in) begin
        bus.in_valid = 1'b1;
        bus.in_word  = 32'hDEADBEEF;
        check("in_ready_emit", 32'(bus.in_ready), 0);
      end
      if (n_hs == stop_at) break;
      if (n_hs == abort_at) begin
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        break;
      end
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        got_w[n_hs] = bus.out_w;
        check($sformatf("idx%0d", n_hs), 32'(bus.out_idx), 32'(n_hs));
        check($sformatf("last%0d", n_hs), 32'(bus.out_last), 32'(n_hs == 63));
        n_hs++;
        held = 1'b0;
      end else begin
        held = bus.out_valid;
        hw   = bus.out_w;
        hi   = bus.out_idx;
      end
      step();
      guard++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_word   = 32'h0;
    if (abort_at < 0 && stop_at < 0) begin
      check("hs_count", 32'(n_hs), 64);
      check("in_ready_after_last", 32'(bus.in_ready), 1);
      check("valid_after_last", 32'(bus.out_valid), 0);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int t = 0; t < 64; t++) check($sformatf("%s_w%0d", tag, t), got_w[t], exp_w[t]);
    $display("block %s: %0d handshakes, errors so far %0d", tag, n_hs, n_bad);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_out_w"}, bus.out_w, 32'h0);
    check({tag, "_out_idx"}, 32'(bus.out_idx), 0);
    check({tag, "_out_last"}, 32'(bus.out_last), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.abort = 1'b0;   bus.in_valid = 1'b0;   bus.in_word = 32'h0;   bus.out_ready = 1'b0;
    bus16.abort = 1'b0; bus16.in_valid = 1'b0; bus16.in_word = 32'h0; bus16.out_ready = 1'b0;

    repeat (3) step();
    check_idle("reset");
    RST = 1'b0;
    step();

    // "abc" block, no stalls, plus known FIPS 180-4 schedule words.
    set_abc();
    send_block(1'b0);
    collect(1'b0, 1'b0, -1, -1);
    compare_all("abc");
    check("abc_w0", got_w[0], 32'h61626380);
    check("abc_w15", got_w[15], 32'h00000018);
    check("abc_w16", got_w[16], 32'h61626380);
    check("abc_w17", got_w[17], 32'h000F0000);
    check("abc_w18", got_w[18], 32'h7DA86405);
    check("abc_w19", got_w[19], 32'h600003C6);

    // Random backpressure, input gaps, in_valid held high during EMIT.
    send_block(1'b1);
    collect(1'b1, 1'b1, -1, -1);
    compare_all("stall");

    // Back-to-back: all-ones then "abc".
    set_ones();
    send_block(1'b0);
    collect(1'b0, 1'b0, -1, -1);
    compare_all("ones");
    check("ones_w16", got_w[16], 32'h203FFFFC);
    set_abc();
    send_block(1'b0);
    collect(1'b0, 1'b0, -1, -1);
    compare_all("b2b");

    // abort while word 7 is presented.
    for (int i = 0; i < 7; i++) send_word(msg[i]);
    check("busy_mid_load", 32'(bus.busy), 1);
    bus.in_valid = 1'b1;
    bus.in_word  = 32'h12345678;
    bus.abort    = 1'b1;
    step();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("abort_load");
    send_block(1'b0);
    collect(1'b0, 1'b0, -1, -1);
    compare_all("post_abort_load");

    // abort at EMIT idx 30 with out_ready high.
    send_block(1'b0);
    collect(1'b0, 1'b0, 30, -1);
    check_idle("abort_emit");
    send_block(1'b0);
    collect(1'b0, 1'b0, -1, -1);
    compare_all("post_abort_emit");

    // Asynchronous reset between edges in the middle of EMIT.
    send_block(1'b0);
    collect(1'b0, 1'b0, -1, 20);
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    #2;
    RST = 1'b1;
    #1;
    check_idle("async_rst");
    step();
    RST = 1'b0;
    step();
    send_block(1'b0);
    collect(1'b0, 1'b0, -1, -1);
    compare_all("post_rst");

    // ROUNDS = 16 instance: only W0..W15, out_last on idx 15.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("r16_in_ready%0d", i), 32'(bus16.in_ready), 1);
      bus16.in_valid = 1'b1;
      bus16.in_word  = msg[i];
      step();
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    for (int t = 0; t < 17; t++) begin
      if (t < 16) begin
        check($sformatf("r16_valid%0d", t), 32'(bus16.out_valid), 1);
        check($sformatf("r16_w%0d", t), bus16.out_w, exp_w[t]);
        check($sformatf("r16_idx%0d", t), 32'(bus16.out_idx), 32'(t));
        check($sformatf("r16_last%0d", t), 32'(bus16.out_last), 32'(t == 15));
      end else begin
        check("r16_done_valid", 32'(bus16.out_valid), 0);
        check("r16_done_in_ready", 32'(bus16.in_ready), 1);
      end
      step();
    end
    bus16.out_ready = 1'b0;
    $display("block r16: 16 words, errors so far %0d", n_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
